clk_div_multi: RTL and testbench

- Parametrised multi-channel clock divider and tick generator driven by the 100 MHz board clock.
- Each channel produces a 50%-duty divided clock and a one-cycle tick strobe.
- Each channel has a runtime-programmable half-period, a per-channel enable and glitch-free divisor reload.
- Successor to the fixed two-output generator. Feeds display scan, debounce and slow-step logic.

---
 rtl/clk_div_pkg.sv | 16 +
 rtl/clk_div_ch.sv | 96 +++++++++
 rtl/clk_div_multi.sv | 40 ++++
 tb/tb_clk_div_multi.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Half-period values are counted in cycles of the 100 MHz system clock.
package clk_div_pkg;

    localparam int unsigned SYS_CLK_HZ    = 100_000_000;
    localparam int unsigned DEFAULT_CNT_W = 28;

    localparam int unsigned HALF_5KHZ = 10_000;
    localparam int unsigned HALF_4SEC = 200_000_000;

    // Half-period in system-clock cycles for a requested output frequency.
    function automatic int unsigned half_for_hz(input int unsigned hz);
        return SYS_CLK_HZ / (2 * hz);
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: half-period counter, output toggle, rising-edge tick and shadow/active divisor.
// Define CLK_DIV_SYNC_EN to add sync_rst, which zeroes the phase and applies any pending divisor.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int unsigned          CNT_W     = DEFAULT_CNT_W,
    parameter logic [CNT_W-1:0]     INIT_HALF = CNT_W'(HALF_5KHZ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] div_in,
`ifdef CLK_DIV_SYNC_EN
    input  logic             sync_rst,
`endif
    output logic             clk_out,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] active;
    logic [CNT_W-1:0] active_nxt;
    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] shadow_nxt;
    logic [CNT_W-1:0] latest;
    logic             pending;
    logic             pending_nxt;
    logic             clk_nxt;
    logic             tick_nxt;
    logic             stalled;
    logic             boundary;

    always_comb begin
        stalled     = (active == '0);
        boundary    = (cnt == active - CNT_W'(1));
        // A load coinciding with an apply point wins over the older shadow value.
        latest      = load ? div_in : shadow;
        cnt_nxt     = cnt;
        clk_nxt     = clk_out;
        tick_nxt    = 1'b0;
        active_nxt  = active;
        shadow_nxt  = latest;
        pending_nxt = pending | load;
`ifdef CLK_DIV_SYNC_EN
        if (sync_rst) begin
            cnt_nxt = '0;
            clk_nxt = 1'b0;
            if (pending || load) begin
                active_nxt  = latest;
                pending_nxt = 1'b0;
            end
        end else
`endif
        if (!en || stalled) begin
            cnt_nxt = '0;
            if (!en) begin
                clk_nxt = 1'b0;
            end
            if (pending) begin
                active_nxt  = shadow;
                pending_nxt = load;
            end
        end else if (boundary) begin
            cnt_nxt  = '0;
            clk_nxt  = !clk_out;
            tick_nxt = !clk_out;
            if (pending || load) begin
                active_nxt  = latest;
                pending_nxt = 1'b0;
            end
        end else begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            active  <= INIT_HALF;
            shadow  <= INIT_HALF;
            pending <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            clk_out <= clk_nxt;
            tick    <= tick_nxt;
            active  <= active_nxt;
            shadow  <= shadow_nxt;
            pending <= pending_nxt;
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// NUM_CH independent 50%-duty clock dividers with one-cycle rising-edge tick strobes.
// Define CLK_DIV_SYNC_EN to add sync_rst, a synchronous phase alignment of all channels.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int unsigned              NUM_CH    = 2,
    parameter int unsigned              CNT_W     = DEFAULT_CNT_W,
    parameter logic [NUM_CH*CNT_W-1:0]  INIT_HALF = {CNT_W'(HALF_4SEC), CNT_W'(HALF_5KHZ)}
) (
    input  logic                    clk100MHz,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH*CNT_W-1:0] div_in,
`ifdef CLK_DIV_SYNC_EN
    input  logic                    sync_rst,
`endif
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_ch #(
            .CNT_W     (CNT_W),
            .INIT_HALF (INIT_HALF[i*CNT_W +: CNT_W])
        ) u_ch (
            .clk      (clk100MHz),
            .rst      (rst),
            .en       (en[i]),
            .load     (load[i]),
            .div_in   (div_in[i*CNT_W +: CNT_W]),
`ifdef CLK_DIV_SYNC_EN
            .sync_rst (sync_rst),
`endif
            .clk_out  (clk_out[i]),
            .tick     (tick[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: directed scenarios plus random en/load traffic
// compared against a segment-based arithmetic model of each channel's waveform.
module tb_clk_div_multi;

    localparam int unsigned NCH = 2;
    localparam int unsigned W   = 8;
    localparam logic [NCH*W-1:0] INIT = {8'd4, 8'd3};

    logic               clk100MHz = 1'b0;
    logic               rst;
    logic [NCH-1:0]     en;
    logic [NCH-1:0]     load;
    logic [NCH*W-1:0]   div_in;
    logic [NCH-1:0]     clk_out;
    logic [NCH-1:0]     tick;

    int errors = 0;
    int checks = 0;

    // Model: each channel's output is a run of equal half-periods starting at a segment
    // origin; level = start level xor parity of (elapsed / H). A segment restarts on reload.
    int   m_h    [NCH];
    int   m_sh   [NCH];
    int   m_el   [NCH];
    bit   m_pend [NCH];
    logic m_lvl0 [NCH];
    logic [NCH-1:0] exp_clk;
    logic [NCH-1:0] exp_tick;

    clk_div_multi #(
        .NUM_CH    (NCH),
        .CNT_W     (W),
        .INIT_HALF (INIT)
    ) dut (
        .clk100MHz (clk100MHz),
        .rst       (rst),
        .en        (en),
        .load      (load),
        .div_in    (div_in),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    always #5 clk100MHz = ~clk100MHz;

    task automatic model_reset();
        logic [NCH*W-1:0] v;
        v = INIT;
        for (int i = 0; i < NCH; i++) begin
            m_h[i]    = int'(v[i*W +: W]);
            m_sh[i]   = m_h[i];
            m_el[i]   = 0;
            m_pend[i] = 1'b0;
            m_lvl0[i] = 1'b0;
        end
        exp_clk  = '0;
        exp_tick = '0;
    endtask

    task automatic model_step(input logic [NCH-1:0] e, input logic [NCH-1:0] ld,
                              input logic [NCH*W-1:0] d);
        for (int i = 0; i < NCH; i++) begin
            int   nv;
            logic lvl;
            bit   bnd;
            nv = int'(d[i*W +: W]);
            if (!e[i] || m_h[i] == 0) begin
                if (!e[i]) exp_clk[i] = 1'b0;
                m_el[i]     = 0;
                m_lvl0[i]   = exp_clk[i];
                exp_tick[i] = 1'b0;
                if (m_pend[i]) m_h[i] = m_sh[i];
                m_pend[i] = ld[i];
                if (ld[i]) m_sh[i] = nv;
            end else begin
                m_el[i]++;
                lvl = m_lvl0[i] ^ (((m_el[i] / m_h[i]) % 2) == 1);
                bnd = (m_el[i] % m_h[i]) == 0;
                exp_tick[i] = bnd && lvl;
                exp_clk[i]  = lvl;
                if (ld[i]) begin
                    m_sh[i]   = nv;
                    m_pend[i] = 1'b1;
                end
                if (bnd && m_pend[i]) begin
                    m_h[i]    = m_sh[i];
                    m_pend[i] = 1'b0;
                    m_el[i]   = 0;
                    m_lvl0[i] = lvl;
                end
            end
        end
    endtask

    // Drives inputs ahead of the edge, advances the model, then samples 1 ns later.
    task automatic drive_cycle(input logic [NCH-1:0] e, input logic [NCH-1:0] ld,
                               input logic [NCH*W-1:0] d);
        en     = e;
        load   = ld;
        div_in = d;
        @(posedge clk100MHz);
        model_step(e, ld, d);
        #1;
        load = '0;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        en     = '0;
        load   = '0;
        div_in = '0;
        model_reset();
        repeat (2) @(posedge clk100MHz);
        #1;
        checks++;
        if (clk_out !== 2'b00) begin
            errors++;
            $display("FAIL reset_clk_out got=%b want=00", clk_out);
        end
        checks++;
        if (tick !== 2'b00) begin
            errors++;
            $display("FAIL reset_tick got=%b want=00", tick);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int rise0[$];
        int rise1[$];
        logic [NCH-1:0] prev;
        prev = clk_out;
        for (int c = 1; c <= 30; c++) begin
            drive_cycle(2'b11, 2'b00, '0);
            checks++;
            if (clk_out !== exp_clk || tick !== exp_tick) begin
                errors++;
                $display("FAIL basic c=%0d clk_out=%b tick=%b want clk_out=%b tick=%b",
                         c, clk_out, tick, exp_clk, exp_tick);
            end
            if (clk_out[0] && !prev[0]) rise0.push_back(c);
            if (clk_out[1] && !prev[1]) rise1.push_back(c);
            prev = clk_out;
        end
        checks++;
        if (rise0.size() < 2 || rise0[0] != 3 || rise0[1] != 9) begin
            errors++;
            $display("FAIL basic_ch0_rises got=%p want first=3 second=9", rise0);
        end
        checks++;
        if (rise1.size() < 2 || rise1[0] != 4 || rise1[1] != 12) begin
            errors++;
            $display("FAIL basic_ch1_rises got=%p want first=4 second=12", rise1);
        end
    endtask

    task automatic test_reload();
        bit found;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            drive_cycle(2'b11, 2'b00, '0);
            checks++;
            if (clk_out !== exp_clk || tick !== exp_tick) begin
                errors++;
                $display("FAIL reload_wait c=%0d clk_out=%b tick=%b want clk_out=%b tick=%b",
                         c, clk_out, tick, exp_clk, exp_tick);
            end
            found = tick[0];
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reload_tick_timeout got=none want=tick[0] within 40 cycles");
        end
        // Load 5 one cycle into the high phase; that phase must still last 3 cycles.
        drive_cycle(2'b11, 2'b01, {8'd0, 8'd5});
        for (int c = 0; c < 40; c++) begin
            drive_cycle(2'b11, 2'b00, '0);
            checks++;
            if (clk_out !== exp_clk || tick !== exp_tick) begin
                errors++;
                $display("FAIL reload c=%0d clk_out=%b tick=%b want clk_out=%b tick=%b",
                         c, clk_out, tick, exp_clk, exp_tick);
            end
        end
    endtask

    task automatic test_stall();
        int ticks0;
        drive_cycle(2'b11, 2'b01, {8'd0, 8'd0});
        ticks0 = 0;
        for (int c = 0; c < 24; c++) begin
            drive_cycle(2'b11, 2'b00, '0);
            checks++;
            if (clk_out !== exp_clk || tick !== exp_tick) begin
                errors++;
                $display("FAIL stall c=%0d clk_out=%b tick=%b want clk_out=%b tick=%b",
                         c, clk_out, tick, exp_clk, exp_tick);
            end
            if (c >= 12 && tick[0]) ticks0++;
        end
        checks++;
        if (ticks0 != 0) begin
            errors++;
            $display("FAIL stall_ticks got=%0d want=0", ticks0);
        end
        drive_cycle(2'b11, 2'b01, {8'd0, 8'd2});
        for (int c = 0; c < 20; c++) begin
            drive_cycle(2'b11, 2'b00, '0);
            checks++;
            if (clk_out !== exp_clk || tick !== exp_tick) begin
                errors++;
                $display("FAIL resume c=%0d clk_out=%b tick=%b want clk_out=%b tick=%b",
                         c, clk_out, tick, exp_clk, exp_tick);
            end
        end
    endtask

    task automatic test_enable_drop();
        int   h0;
        int   rise_at;
        logic prev0;
        for (int c = 0; c < 20 && !clk_out[0]; c++) drive_cycle(2'b11, 2'b00, '0);
        drive_cycle(2'b10, 2'b00, '0);
        checks++;
        if (clk_out[0] !== 1'b0 || clk_out !== exp_clk) begin
            errors++;
            $display("FAIL en_drop clk_out=%b want=%b (ch0 low)", clk_out, exp_clk);
        end
        repeat (3) drive_cycle(2'b10, 2'b00, '0);
        h0      = m_h[0];
        rise_at = -1;
        prev0   = clk_out[0];
        for (int c = 1; c <= 20; c++) begin
            drive_cycle(2'b11, 2'b00, '0);
            checks++;
            if (clk_out !== exp_clk || tick !== exp_tick) begin
                errors++;
                $display("FAIL reenable c=%0d clk_out=%b tick=%b want clk_out=%b tick=%b",
                         c, clk_out, tick, exp_clk, exp_tick);
            end
            if (rise_at < 0 && clk_out[0] && !prev0) rise_at = c;
            prev0 = clk_out[0];
        end
        checks++;
        if (rise_at != h0) begin
            errors++;
            $display("FAIL reenable_first_rise got=%0d want=%0d", rise_at, h0);
        end
    endtask

    task automatic test_back_to_back();
        drive_cycle(2'b11, 2'b10, {8'd2, 8'd0});
        drive_cycle(2'b11, 2'b10, {8'd5, 8'd0});
        for (int c = 0; c < 40; c++) begin
            drive_cycle(2'b11, 2'b00, '0);
            checks++;
            if (clk_out !== exp_clk || tick !== exp_tick) begin
                errors++;
                $display("FAIL back_to_back c=%0d clk_out=%b tick=%b want clk_out=%b tick=%b",
                         c, clk_out, tick, exp_clk, exp_tick);
            end
        end
    endtask

    task automatic test_async_reset();
        int   rise1;
        logic prev1;
        drive_cycle(2'b11, 2'b10, {8'd6, 8'd0});
        for (int c = 0; c < 30; c++) drive_cycle(2'b11, 2'b00, '0);
        for (int c = 0; c < 20 && clk_out == 2'b00; c++) drive_cycle(2'b11, 2'b00, '0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (clk_out !== 2'b00 || tick !== 2'b00) begin
            errors++;
            $display("FAIL async_reset clk_out=%b tick=%b want 00/00", clk_out, tick);
        end
        model_reset();
        en = '0;
        @(posedge clk100MHz);
        #3 rst = 1'b0;
        rise1 = -1;
        prev1 = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            drive_cycle(2'b11, 2'b00, '0);
            checks++;
            if (clk_out !== exp_clk || tick !== exp_tick) begin
                errors++;
                $display("FAIL post_reset c=%0d clk_out=%b tick=%b want clk_out=%b tick=%b",
                         c, clk_out, tick, exp_clk, exp_tick);
            end
            if (rise1 < 0 && clk_out[1] && !prev1) rise1 = c;
            prev1 = clk_out[1];
        end
        checks++;
        if (rise1 != 4) begin
            errors++;
            $display("FAIL post_reset_ch1_rise got=%0d want=4", rise1);
        end
    endtask

    task automatic test_random();
        logic [NCH-1:0]   e;
        logic [NCH-1:0]   ld;
        logic [NCH*W-1:0] d;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NCH; i++) begin
                e[i]        = ($urandom_range(15) != 0);
                ld[i]       = ($urandom_range(9) == 0);
                d[i*W +: W] = 8'($urandom_range(6));
            end
            drive_cycle(e, ld, d);
            checks++;
            if (clk_out !== exp_clk || tick !== exp_tick) begin
                errors++;
                $display("FAIL random c=%0d clk_out=%b tick=%b want clk_out=%b tick=%b",
                         c, clk_out, tick, exp_clk, exp_tick);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reload();
        test_stall();
        test_enable_drop();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
